// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forward select generation for the pipelined MIPS core.
// Producers are tracked in a shadow pipeline (stages 1..DEPTH); unforwardable load-use cases stall ID.
module hazard_forward_unit #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_RDY = 3,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IdValid,
  input  logic [ADDR_W-1:0]      IdDst,
  input  logic                   IdRegWrite,
  input  logic                   IdMemToReg,
  input  logic [NSRC*ADDR_W-1:0] IdSrc,
  input  logic [NSRC-1:0]        IdSrcUsed,
  input  logic                   IdIsStore,
  input  logic                   Flush,
  output logic                   Stall,
  output logic [NSRC*SEL_W-1:0]  FwdSelEx,
  output logic                   StoreFwdMem,
  output logic [CNT_W-1:0]       StallCount
);

  logic              sh_valid [1:DEPTH];
  logic [ADDR_W-1:0] sh_dst   [1:DEPTH];
  logic              sh_rw    [1:DEPTH];
  logic              sh_load  [1:DEPTH];

  logic [NSRC*SEL_W-1:0] sel_c;
  logic                  late_c;
  logic                  hazard_c;
  logic                  capture;
  logic                  ex_late;
  logic [ADDR_W-1:0]     src_cur;
  int                    hit_k;
  logic                  hit_load;

  always_comb begin
    sel_c    = '0;
    late_c   = 1'b0;
    hazard_c = 1'b0;
    src_cur  = '0;
    hit_k    = 0;
    hit_load = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      src_cur  = IdSrc[s*ADDR_W +: ADDR_W];
      hit_k    = 0;
      hit_load = 1'b0;
      // scanning oldest to youngest lets the youngest producer win
      for (int k = DEPTH; k >= 1; k--) begin
        if (sh_valid[k] && sh_rw[k] && IdSrcUsed[s] &&
            sh_dst[k] == src_cur && sh_dst[k] != '0) begin
          hit_k    = k;
          hit_load = sh_load[k];
        end
      end
      if (hit_k != 0 && hit_k != DEPTH) begin
        if (!hit_load || hit_k + 1 >= LOAD_RDY)
          sel_c[s*SEL_W +: SEL_W] = SEL_W'(hit_k + 1);
        else if (s == NSRC - 1 && IdIsStore && hit_k + 2 >= LOAD_RDY)
          late_c = 1'b1;
        else
          hazard_c = 1'b1;
      end
    end
  end

  assign Stall   = IdValid && !Flush && hazard_c;
  assign capture = IdValid && !Stall && !Flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sh_valid[k] <= 1'b0;
        sh_dst[k]   <= '0;
        sh_rw[k]    <= 1'b0;
        sh_load[k]  <= 1'b0;
      end
    end else begin
      sh_valid[1] <= capture;
      sh_dst[1]   <= IdDst;
      sh_rw[1]    <= IdRegWrite;
      sh_load[1]  <= IdMemToReg;
      for (int k = 2; k <= DEPTH; k++) begin
        sh_valid[k] <= sh_valid[k-1];
        sh_dst[k]   <= sh_dst[k-1];
        sh_rw[k]    <= sh_rw[k-1];
        sh_load[k]  <= sh_load[k-1];
      end
    end
  end

  // late store-data flag rides with the store: EX copy, then MEM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FwdSelEx    <= '0;
      ex_late     <= 1'b0;
      StoreFwdMem <= 1'b0;
      StallCount  <= '0;
    end else begin
      FwdSelEx    <= capture ? sel_c : '0;
      ex_late     <= capture && late_c;
      StoreFwdMem <= ex_late;
      if (Stall && StallCount != {CNT_W{1'b1}})
        StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: a list-based pipeline model predicts each ID decision.
// A second instance with DEPTH = LOAD_RDY = 4 covers the multi-cycle stall cases.
module tb_hazard_forward_unit;
  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IdValid = 1'b0;
  logic [4:0]  IdDst = '0;
  logic        IdRegWrite = 1'b0;
  logic        IdMemToReg = 1'b0;
  logic [9:0]  IdSrc = '0;
  logic [1:0]  IdSrcUsed = '0;
  logic        IdIsStore = 1'b0;
  logic        Flush = 1'b0;
  logic        Stall;
  logic [3:0]  FwdSelEx;
  logic        StoreFwdMem;
  logic [15:0] StallCount;
  logic        stall4;
  logic [5:0]  fwd4;
  logic        sfm4;
  logic [15:0] cnt4;

  always #5 clk = ~clk;

  hazard_forward_unit #(.ADDR_W(5), .DEPTH(3), .NSRC(2), .LOAD_RDY(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .IdValid(IdValid), .IdDst(IdDst), .IdRegWrite(IdRegWrite),
    .IdMemToReg(IdMemToReg), .IdSrc(IdSrc), .IdSrcUsed(IdSrcUsed), .IdIsStore(IdIsStore),
    .Flush(Flush), .Stall(Stall), .FwdSelEx(FwdSelEx), .StoreFwdMem(StoreFwdMem),
    .StallCount(StallCount));

  hazard_forward_unit #(.ADDR_W(5), .DEPTH(4), .NSRC(2), .LOAD_RDY(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .IdValid(IdValid), .IdDst(IdDst), .IdRegWrite(IdRegWrite),
    .IdMemToReg(IdMemToReg), .IdSrc(IdSrc), .IdSrcUsed(IdSrcUsed), .IdIsStore(IdIsStore),
    .Flush(Flush), .Stall(stall4), .FwdSelEx(fwd4), .StoreFwdMem(sfm4), .StallCount(cnt4));

  typedef struct { logic v; logic [4:0] dst; logic rw; logic ld; } ent_t;
  typedef struct { logic [3:0] fwd; logic late; logic stall; int cyc; } exp_t;
  typedef struct {
    logic v; logic [4:0] dst; logic rw; logic ld;
    logic [4:0] s0; logic [4:0] s1; logic [1:0] used; logic st; logic fl;
  } ins_t;

  ent_t hist[$];   // hist[0] = instruction in EX, hist[1] = MEM, ...
  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  logic mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Where can a consumer in EX get this source from?
  task automatic eval_src(input logic [4:0] src, input logic used, input logic store_data,
                          output int sel, output logic late, output logic haz);
    int   stage;
    logic ld;
    int   ready;
    stage = 0; ld = 1'b0; sel = 0; late = 1'b0; haz = 1'b0;
    if (used && src != 5'd0)
      for (int d = hist.size() - 1; d >= 0; d--)
        if (hist[d].v && hist[d].rw && hist[d].dst == src) begin
          stage = d + 1;
          ld = hist[d].ld;
        end
    if (stage != 0 && stage < DEPTH) begin
      ready = ld ? LOAD_RDY : 1;
      if (stage + 1 >= ready) sel = stage + 1;
      else if (store_data && stage + 2 >= ready) late = 1'b1;
      else haz = 1'b1;
    end
  endtask

  task automatic issue(input ins_t in, output logic stl);
    int   sel0, sel1;
    logic late0, late1, haz0, haz1, cap;
    exp_t it;
    ent_t e;
    @(posedge clk); #1;
    IdValid = in.v; IdDst = in.dst; IdRegWrite = in.rw; IdMemToReg = in.ld;
    IdSrc = {in.s1, in.s0}; IdSrcUsed = in.used; IdIsStore = in.st; Flush = in.fl;
    #1;
    eval_src(in.s0, in.used[0], 1'b0, sel0, late0, haz0);
    eval_src(in.s1, in.used[1], in.st, sel1, late1, haz1);
    stl = in.v && !in.fl && (haz0 || haz1);
    check("stall", 32'(Stall), 32'(stl));
    cap = in.v && !stl && !in.fl;
    it.fwd   = cap ? {2'(sel1), 2'(sel0)} : 4'd0;
    it.late  = cap && (late0 || late1);
    it.stall = stl;
    it.cyc   = cyc;
    exp_q.push_back(it);
    e.v = cap; e.dst = in.dst; e.rw = in.rw; e.ld = in.ld;
    hist.push_front(e);
    while (hist.size() > DEPTH) void'(hist.pop_back());
  endtask

  task automatic run(input logic v, input logic [4:0] dst, input logic rw, input logic ld,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                     input logic st, input logic fl);
    ins_t in;
    logic stl;
    int   n;
    in.v = v; in.dst = dst; in.rw = rw; in.ld = ld; in.s0 = s0; in.s1 = s1;
    in.used = used; in.st = st; in.fl = fl;
    n = 0;
    do begin
      issue(in, stl);
      n++;
    end while (stl && n < 8);
    if (stl) begin
      n_err++;
      $display("FAIL hold_bound: stall=%0d after %0d cycles, required 0", stl, n);
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) run(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // monitor: compares registered outputs for every instruction once it has reached EX
  initial begin
    exp_t        it;
    int unsigned exp_cnt;
    logic        prev_late, have_prev;
    exp_cnt = 0; prev_late = 1'b0; have_prev = 1'b0;
    forever begin
      @(posedge clk); #3;
      if (mon_en && exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        it = exp_q.pop_front();
        exp_cnt += 32'(it.stall);
        check("fwd_sel_ex", 32'(FwdSelEx), 32'(it.fwd));
        check("stall_count", 32'(StallCount), exp_cnt);
        if (have_prev) check("store_fwd_mem", 32'(StoreFwdMem), 32'(prev_late));
        prev_late = it.late;
        have_prev = 1'b1;
      end else if (mon_en && have_prev) begin
        check("store_fwd_mem_tail", 32'(StoreFwdMem), 32'(prev_late));
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    ins_t in;
    logic stl, held;

    // reset with a hazard-looking instruction on the inputs
    rst_n = 1'b0; IdValid = 1'b1; IdDst = 5'd5; IdRegWrite = 1'b1; IdMemToReg = 1'b1;
    IdSrc = 10'($urandom); IdSrcUsed = 2'b11; IdIsStore = 1'b1; Flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_stall", 32'(Stall), 0);
    check("rst_fwd", 32'(FwdSelEx), 0);
    check("rst_sfm", 32'(StoreFwdMem), 0);
    check("rst_cnt", 32'(StallCount), 0);
    check("rst_stall4", 32'(stall4), 0);
    IdValid = 1'b0;
    #1 rst_n = 1'b1;
    hist.delete();

    // directed cases
    nops(2);
    run(1, 3, 1, 0, 1, 2, 2'b11, 0, 0);   // add r3
    run(1, 9, 1, 0, 3, 4, 2'b11, 0, 0);   // or r9 <- r3 : sel 2
    nops(3);
    run(1, 3, 1, 0, 1, 2, 2'b11, 0, 0);
    nops(1);
    run(1, 9, 1, 0, 3, 4, 2'b11, 0, 0);   // sel 3
    nops(3);
    run(1, 3, 1, 0, 1, 2, 2'b11, 0, 0);
    nops(2);
    run(1, 9, 1, 0, 3, 4, 2'b11, 0, 0);   // sel 0
    nops(3);
    run(1, 5, 1, 1, 29, 0, 2'b01, 0, 0);  // lw r5
    run(1, 6, 1, 0, 5, 2, 2'b11, 0, 0);   // add r6 <- r5 : one stall, then sel 3
    nops(3);
    run(1, 7, 1, 1, 29, 0, 2'b01, 0, 0);  // lw r7
    run(1, 0, 0, 0, 8, 7, 2'b11, 1, 0);   // sw r7 data : late forward
    nops(3);
    run(1, 7, 1, 1, 29, 0, 2'b01, 0, 0);
    run(1, 0, 0, 0, 7, 9, 2'b11, 1, 0);   // sw with r7 base : stall
    nops(3);
    run(1, 0, 1, 1, 29, 0, 2'b01, 0, 0);  // lw r0
    run(1, 1, 1, 0, 0, 0, 2'b11, 0, 0);   // r0 never matches
    nops(3);
    run(1, 4, 1, 0, 1, 2, 2'b11, 0, 0);   // add r4
    run(1, 4, 1, 0, 2, 3, 2'b11, 0, 0);   // sub r4
    run(1, 10, 1, 0, 4, 4, 2'b11, 0, 0);  // consumer : sel 2 on both
    nops(3);
    run(1, 5, 1, 1, 29, 0, 2'b01, 0, 0);
    run(1, 6, 1, 0, 5, 2, 2'b11, 0, 1);   // flushed consumer : no stall, bubble
    nops(3);

    // randomized traffic over a small register window to provoke dependencies
    held = 1'b0;
    in = '{default: '0};
    for (int i = 0; i < 600; i++) begin
      if (!held) begin
        in.v    = ($urandom_range(0, 9) != 0);
        in.st   = ($urandom_range(0, 4) == 0);
        in.ld   = !in.st && ($urandom_range(0, 2) == 0);
        in.rw   = !in.st && (in.ld || $urandom_range(0, 4) != 0);
        in.dst  = 5'($urandom_range(0, 7));
        in.s0   = 5'($urandom_range(0, 7));
        in.s1   = 5'($urandom_range(0, 7));
        in.used = 2'($urandom_range(0, 3));
      end
      in.fl = ($urandom_range(0, 11) == 0);
      issue(in, stl);
      held = stl;
    end

    // drain the scoreboard
    @(posedge clk); #1;
    IdValid = 1'b0; Flush = 1'b0; IdIsStore = 1'b0;
    repeat (4) @(posedge clk);
    #4 mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d items left, required 0", exp_q.size());
    end

    // reset asserted and released in the middle of a load-use stall
    @(posedge clk); #1;
    IdValid = 1'b1; IdDst = 5'd5; IdRegWrite = 1'b1; IdMemToReg = 1'b1; IdSrcUsed = 2'b00;
    @(posedge clk); #1;
    IdDst = 5'd6; IdMemToReg = 1'b0; IdSrc = {5'd2, 5'd5}; IdSrcUsed = 2'b11;
    #1 check("midrst_pre_stall", 32'(Stall), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 32'(Stall), 0);
    check("midrst_fwd", 32'(FwdSelEx), 0);
    check("midrst_sfm", 32'(StoreFwdMem), 0);
    check("midrst_cnt", 32'(StallCount), 0);
    rst_n = 1'b1;
    #1 check("rst_release_stall", 32'(Stall), 0);

    // DEPTH = LOAD_RDY = 4 instance: two-cycle load-use stall
    @(posedge clk); #1 IdValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    IdValid = 1'b1; IdDst = 5'd5; IdRegWrite = 1'b1; IdMemToReg = 1'b1; IdSrcUsed = 2'b00;
    @(posedge clk); #1;
    IdDst = 5'd6; IdMemToReg = 1'b0; IdSrc = {5'd2, 5'd5}; IdSrcUsed = 2'b11;
    #1 check("d4_lu_stall_1", 32'(stall4), 1);
    @(posedge clk); #2 check("d4_lu_stall_2", 32'(stall4), 1);
    @(posedge clk); #2 check("d4_lu_stall_3", 32'(stall4), 0);
    @(posedge clk); #1 IdValid = 1'b0;
    #1;
    check("d4_lu_sel", 32'(fwd4), 32'd4);
    check("d4_lu_cnt", 32'(cnt4), 2);

    // DEPTH = LOAD_RDY = 4 instance: store data waits one cycle, then forwards late
    repeat (4) @(posedge clk);
    #1;
    IdValid = 1'b1; IdDst = 5'd7; IdRegWrite = 1'b1; IdMemToReg = 1'b1; IdSrcUsed = 2'b00;
    @(posedge clk); #1;
    IdDst = 5'd0; IdRegWrite = 1'b0; IdMemToReg = 1'b0; IdSrc = {5'd7, 5'd8};
    IdSrcUsed = 2'b11; IdIsStore = 1'b1;
    #1 check("d4_st_stall_1", 32'(stall4), 1);
    @(posedge clk); #2 check("d4_st_stall_2", 32'(stall4), 0);
    @(posedge clk); #1 IdValid = 1'b0; IdIsStore = 1'b0;
    #1;
    check("d4_st_sel", 32'(fwd4), 0);
    check("d4_st_cnt", 32'(cnt4), 3);
    check("d4_st_sfm_ex", 32'(sfm4), 0);
    @(posedge clk); #2 check("d4_st_sfm", 32'(sfm4), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
